// File: rtl/count_seq_checker_pkg.sv
// count_seq_checker_pkg: shared state codes, pin bit positions and output packing for the count checker
package count_seq_checker_pkg;

    localparam logic [1:0] ST_ACQ    = 2'd0;
    localparam logic [1:0] ST_TRACK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam int IN_EN  = 4;
    localparam int IN_CLR = 5;
    localparam int SYNC_W = 6;

    function automatic logic [7:0] pack_out(
        input logic       locked,
        input logic       sticky,
        input logic [1:0] state,
        input logic [3:0] err
    );
        return {err, state, sticky, locked};
    endfunction

endpackage

// File: rtl/io_sync.sv
// io_sync: multi-bit flop-chain synchronizer for pin inputs, async active-high reset
module io_sync #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] chain_q [STAGES];
    logic [W-1:0] chain_d [STAGES];

    // shift the pin value one stage deeper each clock
    always_comb begin
        chain_d[0] = d;
        for (int i = 1; i < STAGES; i++) chain_d[i] = chain_q[i-1];
    end

    // chain registers clear together on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) chain_q[i] <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/count_seq_checker.sv
// count_seq_checker: checks a synchronized incoming count increments by one, reports lock and errors
module count_seq_checker
    import count_seq_checker_pkg::*;
#(
    parameter int CNT_W       = 4,
    parameter int LOCK_N      = 4,
    parameter int ERR_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] io_in,
    output logic [7:0] io_out,
    output logic [7:0] io_oeb
);

    localparam int GR_W = $clog2(LOCK_N + 1);

    logic [SYNC_W-1:0] in_s;
    logic              unused_pins;
    logic [CNT_W-1:0]  sample;
    logic              en;
    logic              clr;
    logic              hit;
    logic [GR_W-1:0]   gr_inc;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  prev_q, prev_d;
    logic [GR_W-1:0]   good_run_q, good_run_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic              err_sticky_q, err_sticky_d;
    logic              locked_q, locked_d;
    logic [7:0]        oeb_q, oeb_d;

    io_sync #(.W(SYNC_W), .STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (io_in[SYNC_W-1:0]),
        .q   (in_s)
    );

    assign unused_pins = ^io_in[7:SYNC_W];
    assign sample      = in_s[CNT_W-1:0];
    assign en          = in_s[IN_EN];
    assign clr         = in_s[IN_CLR];
    assign hit         = sample == prev_q + CNT_W'(1);
    assign gr_inc      = good_run_q + GR_W'(1);

    // sequence FSM: disable forces reacquire, misses only count once locked, clear wins over counting
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        good_run_d   = good_run_q;
        err_cnt_d    = err_cnt_q;
        err_sticky_d = err_sticky_q;
        oeb_d        = 8'h00;
        if (!en) begin
            state_d    = ST_ACQ;
            good_run_d = '0;
        end else begin
            case (state_q)
                ST_ACQ: begin
                    state_d    = ST_TRACK;
                    prev_d     = sample;
                    good_run_d = '0;
                end
                ST_TRACK: begin
                    prev_d     = sample;
                    good_run_d = hit ? gr_inc : '0;
                    state_d    = (hit && gr_inc == GR_W'(LOCK_N)) ? ST_LOCKED : ST_TRACK;
                end
                ST_LOCKED: begin
                    prev_d = sample;
                    if (!hit) begin
                        state_d      = ST_TRACK;
                        good_run_d   = '0;
                        err_sticky_d = 1'b1;
                        err_cnt_d    = (&err_cnt_q) ? err_cnt_q : err_cnt_q + ERR_W'(1);
                    end
                end
                default: begin
                    state_d    = ST_ACQ;
                    good_run_d = '0;
                end
            endcase
        end
        if (clr) begin
            err_cnt_d    = '0;
            err_sticky_d = 1'b0;
        end
        locked_d = state_d == ST_LOCKED;
    end

    // checker state and output enables; reset parks pins as inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_ACQ;
            prev_q       <= '0;
            good_run_q   <= '0;
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
            locked_q     <= 1'b0;
            oeb_q        <= 8'hFF;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            good_run_q   <= good_run_d;
            err_cnt_q    <= err_cnt_d;
            err_sticky_q <= err_sticky_d;
            locked_q     <= locked_d;
            oeb_q        <= oeb_d;
        end
    end

    assign io_out = pack_out(locked_q, err_sticky_q, state_q, 4'(err_cnt_q));
    assign io_oeb = oeb_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// tb_count_seq_checker: directed bench for the count sequence checker
module tb_count_seq_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] io_in;
    logic [7:0] io_out;
    logic [7:0] io_oeb;
    logic [3:0] cur;
    int         checks = 0;
    int         fails = 0;
    int         sat;

    count_seq_checker dut (
        .clk    (clk),
        .rst    (rst),
        .io_in  (io_in),
        .io_out (io_out),
        .io_oeb (io_oeb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // apply one pin value and hold it for one clock; io_out then shows the value applied two calls earlier
    task automatic drive(input logic [3:0] c, input logic e, input logic l);
        io_in = {2'b00, l, e, c};
        @(negedge clk);
    endtask

    task automatic feed(input logic [3:0] c);
        drive(c, 1'b1, 1'b0);
        cur = c;
    endtask

    initial begin
        io_in = 8'($urandom);
        repeat (3) @(negedge clk);
        chk("rst_out", io_out, 8'h00);
        chk("rst_oeb", io_oeb, 8'hFF);
        io_in = 8'($urandom);
        @(negedge clk);
        chk("rst_out_rand", io_out, 8'h00);
        io_in = 8'h00;
        rst   = 1'b0;
        drive(4'd0, 1'b0, 1'b0);
        chk("rel_oeb", io_oeb, 8'h00);
        chk("rel_out", io_out, 8'h00);
        drive(4'd0, 1'b0, 1'b0);
        drive(4'd0, 1'b0, 1'b0);
        feed(4'd0);
        feed(4'd1);
        chk("ramp_acq", io_out, 8'h00);
        feed(4'd2);
        chk("ramp_track", io_out, 8'h04);
        feed(4'd3);
        feed(4'd4);
        feed(4'd5);
        chk("ramp_3hits", io_out, 8'h04);
        feed(4'd6);
        chk("ramp_lock", io_out, 8'h09);
        for (int v = 7; v < 18; v++) feed(4'(v));
        feed(4'd2);
        feed(4'd3);
        chk("ramp_wrap", io_out, 8'h09);
        feed(4'd4);
        feed(4'd5);
        feed(4'd6);
        feed(4'd9);
        feed(4'd10);
        feed(4'd11);
        chk("glitch", io_out, 8'h16);
        feed(4'd12);
        feed(4'd13);
        feed(4'd14);
        chk("glitch_3hits", io_out, 8'h16);
        feed(4'd15);
        chk("glitch_relock", io_out, 8'h1B);
        for (int v = 0; v < 8; v++) feed(4'(v));
        for (int r = 0; r < 20; r++) begin
            if (r == 0) feed(cur);
            else feed(cur + 4'd3);
            repeat (4) feed(cur + 4'd1);
            sat = (r + 2 > 15) ? 15 : r + 2;
            chk($sformatf("sat_r%0d", r), io_out, {sat[3:0], 4'h6});
        end
        feed(cur + 4'd1);
        feed(cur + 4'd1);
        chk("sat_hold_lock", io_out, 8'hFB);
        cur = cur + 4'd3;
        drive(cur, 1'b1, 1'b1);
        feed(cur + 4'd1);
        feed(cur + 4'd1);
        chk("clr_collide", io_out, 8'h04);
        repeat (4) feed(cur + 4'd1);
        chk("clr_relock", io_out, 8'h09);
        feed(cur + 4'd3);
        repeat (4) feed(cur + 4'd1);
        drive(cur, 1'b0, 1'b0);
        chk("endrop_pre", io_out, 8'h16);
        drive(cur, 1'b0, 1'b0);
        chk("endrop_locked", io_out, 8'h1B);
        drive(cur, 1'b0, 1'b0);
        chk("endrop_acq", io_out, 8'h12);
        repeat (6) feed(cur + 4'd1);
        chk("reen_3hits", io_out, 8'h16);
        feed(cur + 4'd1);
        chk("reen_lock", io_out, 8'h1B);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out", io_out, 8'h00);
        chk("async_rst_oeb", io_oeb, 8'hFF);
        #1 rst = 1'b0;
        drive(4'd0, 1'b0, 1'b0);
        chk("post_rst_out", io_out, 8'h00);
        chk("post_rst_oeb", io_oeb, 8'h00);
        drive(4'd0, 1'b0, 1'b0);
        repeat (6) feed(cur + 4'd1);
        chk("post_rst_3hits", io_out, 8'h04);
        feed(cur + 4'd1);
        chk("post_rst_lock", io_out, 8'h09);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
